// File: rtl/cpu_run_controller_pkg.sv
// cpu_ctrl_pkg: run-controller state encoding, end-cause flags and constants
// shared by the controller, its interface and its counters
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  typedef struct packed {
    logic halted;
    logic timeout;
    logic aborted;
  } run_end_t;

  localparam logic [31:0] EBREAK = 32'h00100073;

  function automatic logic is_busy(run_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: host memory-port requests and the gated
// versions forwarded to the core (address/data go straight to cpu)
interface cpu_run_controller_if;

  logic host_wen_ext;
  logic host_ren_ext;
  logic host_wen_ext_2;
  logic host_ren_ext_2;

  logic wen_ext;
  logic ren_ext;
  logic wen_ext_2;
  logic ren_ext_2;

  modport master (
    output host_wen_ext,
    output host_ren_ext,
    output host_wen_ext_2,
    output host_ren_ext_2,
    input  wen_ext,
    input  ren_ext,
    input  wen_ext_2,
    input  ren_ext_2
  );

  modport slave (
    input  host_wen_ext,
    input  host_ren_ext,
    input  host_wen_ext_2,
    input  host_ren_ext_2,
    output wen_ext,
    output ren_ext,
    output wen_ext_2,
    output ren_ext_2
  );

endinterface

// File: rtl/cpu_run_controller_counter.sv
// run_cycle_counter: saturating up-counter with synchronous clear and
// a terminal-match flag; used for both run cycles and pipeline drain
module run_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         match
);

  logic sat;

  assign sat   = &count;
  assign match = (count == terminal);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/drain sequencer and host-port gate for the core
// optional CPU_RUN_STEP_EN adds single-step inputs step and step_mode
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = EBREAK
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [31:0]      instr_if,
`ifdef CPU_RUN_STEP_EN
  input  logic             step,
  input  logic             step_mode,
`endif
  cpu_run_controller_if.slave ext,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic             aborted,
  output logic             ext_conflict,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] DRAIN_TERM =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  // halt/timeout skip DRAIN entirely when there is nothing to drain
  localparam run_state_e END_STATE =
    (DRAIN_CYCLES == 0) ? DONE : DRAIN;

  run_state_e       state_q;
  run_state_e       state_d;
  run_end_t         end_q;
  run_end_t         end_d;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] max_d;
  logic [CNT_W-1:0] max_term;
  logic [CNT_W-1:0] unused_drain_cnt;
  logic             en_d;
  logic             done_d;
  logic             conflict_d;
  logic             host_req;
  logic             start_ok;
  logic             cnt_match;
  logic             drain_match;
  logic             halt_hit;
  logic             limit_hit;
  logic             run_en;
  logic             start_en;

`ifdef CPU_RUN_STEP_EN
  logic step_mode_q;
  logic step_mode_d;

  assign run_en   = !step_mode_q || step;
  assign start_en = !step_mode;
`else
  assign run_en   = 1'b1;
  assign start_en = 1'b1;
`endif

  assign host_req = ext.host_wen_ext   | ext.host_ren_ext |
                    ext.host_wen_ext_2 | ext.host_ren_ext_2;

  assign start_ok  = start && !is_busy(state_q);
  assign max_term  = max_q - CNT_W'(1);
  assign halt_hit  = cpu_enable && (instr_if == HALT_INSTR);
  assign limit_hit = cpu_enable && (max_q != '0) && cnt_match;

  assign halted  = end_q.halted;
  assign timeout = end_q.timeout;
  assign aborted = end_q.aborted;

  assign ext.wen_ext   = ext.host_wen_ext   & ~busy;
  assign ext.ren_ext   = ext.host_ren_ext   & ~busy;
  assign ext.wen_ext_2 = ext.host_wen_ext_2 & ~busy;
  assign ext.ren_ext_2 = ext.host_ren_ext_2 & ~busy;

  run_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (start_ok),
    .en       (cpu_enable),
    .terminal (max_term),
    .count    (cycle_count),
    .match    (cnt_match)
  );

  // held clear outside DRAIN so every drain starts from zero
  run_cycle_counter #(.W(CNT_W)) u_drain_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (state_q != DRAIN),
    .en       (state_q == DRAIN),
    .terminal (DRAIN_TERM),
    .count    (unused_drain_cnt),
    .match    (drain_match)
  );

  always_comb begin
    state_d    = state_q;
    en_d       = cpu_enable;
    done_d     = done;
    end_d      = end_q;
    max_d      = max_q;
    conflict_d = ext_conflict | (busy & host_req);
`ifdef CPU_RUN_STEP_EN
    step_mode_d = step_mode_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          en_d       = start_en;
          done_d     = 1'b0;
          end_d      = '0;
          max_d      = max_cycles;
          conflict_d = 1'b0;
`ifdef CPU_RUN_STEP_EN
          step_mode_d = step_mode;
`endif
        end
      end
      RUN: begin
        en_d = run_en;
        if (stop) begin
          state_d       = DONE;
          en_d          = 1'b0;
          done_d        = 1'b1;
          end_d.aborted = 1'b1;
        end else if (halt_hit) begin
          state_d      = END_STATE;
          en_d         = (END_STATE == DRAIN);
          done_d       = (END_STATE == DONE);
          end_d.halted = 1'b1;
        end else if (limit_hit) begin
          state_d       = END_STATE;
          en_d          = (END_STATE == DRAIN);
          done_d        = (END_STATE == DONE);
          end_d.timeout = 1'b1;
        end
      end
      DRAIN: begin
        en_d = 1'b1;
        if (stop) begin
          state_d       = DONE;
          en_d          = 1'b0;
          done_d        = 1'b1;
          end_d.aborted = 1'b1;
        end else if (drain_match) begin
          state_d = DONE;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      cpu_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      end_q        <= '0;
      ext_conflict <= 1'b0;
      max_q        <= '0;
`ifdef CPU_RUN_STEP_EN
      step_mode_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cpu_enable   <= en_d;
      busy         <= is_busy(state_d);
      done         <= done_d;
      end_q        <= end_d;
      ext_conflict <= conflict_d;
      max_q        <= max_d;
`ifdef CPU_RUN_STEP_EN
      step_mode_q  <= step_mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed + random runs against an arithmetic
// model of run length, end cause and host-port gating
module tb_cpu_run_controller;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam int DRAIN = 4;
  localparam int NONE  = 100000;

  typedef struct packed {
    int h;
    int m;
    int s;
    int j;
    int p;
  } case_t;

  typedef struct packed {
    int count;
    bit halted;
    bit timeout;
    bit aborted;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] max_cycles = '0;
  logic [31:0]      instr_if = 32'h00000013;
  logic             cpu_enable;
  logic             busy;
  logic             done;
  logic             halted;
  logic             timeout;
  logic             aborted;
  logic             ext_conflict;
  logic [CNT_W-1:0] cycle_count;
`ifdef CPU_RUN_STEP_EN
  logic             step = 1'b0;
  logic             step_mode = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  cpu_run_controller_if ext();

  cpu_run_controller #(
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN),
    .HALT_INSTR   (EBREAK)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .stop         (stop),
    .max_cycles   (max_cycles),
    .instr_if     (instr_if),
`ifdef CPU_RUN_STEP_EN
    .step         (step),
    .step_mode    (step_mode),
`endif
    .ext          (ext),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .done         (done),
    .halted       (halted),
    .timeout      (timeout),
    .aborted      (aborted),
    .ext_conflict (ext_conflict),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // h/m/s are 1-based enabled-cycle indices; s==0 means stop with start
  function automatic exp_t model(int h, int m, int s);
    exp_t r;
    int   e;
    int   sv;
    r.count = 0; r.halted = 0; r.timeout = 0; r.aborted = 0;
    sv = (s < 1) ? NONE : s;
    e  = NONE;
    if (h < e) begin e = h; r.halted = 1; end
    if (m != 0 && m < e) begin e = m; r.halted = 0; r.timeout = 1; end
    if (sv <= e) begin
      r.count = sv; r.halted = 0; r.timeout = 0; r.aborted = 1;
    end else if (sv <= e + DRAIN) begin
      r.count = sv; r.aborted = 1;
    end else begin
      r.count = e + DRAIN;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    return (w == EBREAK) ? 32'h00000013 : w;
  endfunction

  function automatic logic [3:0] gated();
    return {ext.wen_ext, ext.ren_ext, ext.wen_ext_2, ext.ren_ext_2};
  endfunction

  task automatic set_host(input logic [3:0] r);
    {ext.host_wen_ext, ext.host_ren_ext,
     ext.host_wen_ext_2, ext.host_ren_ext_2} = r;
  endtask

  task automatic test_reset();
    set_host(4'b0000);
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({cpu_enable, busy, done, halted, timeout, aborted, ext_conflict} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {cpu_enable, busy, done, halted, timeout, aborted, ext_conflict});
    end
    vectors++;
    if (cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", cycle_count);
    end
    vectors++;
    if (gated() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gated: got %b want 0000", gated());
    end
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ext_idle();
    set_host(4'b1111);
    #1;
    vectors++;
    if (gated() !== 4'b1111) begin
      errors++;
      $display("FAIL idle_pass: got %b want 1111", gated());
    end
    @(posedge clk); #1;
    set_host(4'b0000);
    vectors++;
    if (ext_conflict !== 1'b0) begin
      errors++;
      $display("FAIL idle_conflict: got %b want 0", ext_conflict);
    end
  endtask

  task automatic test_runs();
    case_t      dir [7];
    case_t      cs;
    exp_t       e;
    int         jl;
    logic [3:0] one;
    logic [3:0] req;
    logic [3:0] gexp;
    dir[0] = '{10,   0,  NONE, -1, -1};
    dir[1] = '{NONE, 20, NONE, -1, -1};
    dir[2] = '{NONE, 0,  5,    -1, -1};
    dir[3] = '{8,    8,  NONE, -1, -1};
    dir[4] = '{6,    0,  NONE, 3,  2};
    dir[5] = '{4,    0,  6,    -1, -1};
    dir[6] = '{NONE, 3,  0,    -1, -1};
    one = 4'b1000;
    for (int r = 0; r < 47; r++) begin
      jl = 0;
      if (r < 7) begin
        cs = dir[r];
        e  = model(cs.h, cs.m, cs.s);
      end else begin
        cs.h = ($urandom_range(0, 2) == 0) ? NONE : int'($urandom_range(1, 30));
        cs.m = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
        cs.s = ($urandom_range(0, 2) != 0) ? NONE : int'($urandom_range(0, 36));
        if (cs.h == NONE && cs.m == 0 && (cs.s == NONE || cs.s == 0))
          cs.m = int'($urandom_range(1, 30));
        cs.j = int'($urandom_range(0, 45));
        jl   = int'($urandom_range(0, 3));
        e    = model(cs.h, cs.m, cs.s);
        cs.p = ($urandom_range(0, 1) == 1) ?
               int'($urandom_range(0, e.count - 1)) : -1;
      end
      @(posedge clk); #1;
      start      = 1'b1;
      stop       = (cs.s == 0);
      max_cycles = CNT_W'(cs.m);
      instr_if   = rand_instr();
      @(posedge clk); #1;
      for (int k = 0; k <= e.count + 3; k++) begin
        vectors++;
        if ({cpu_enable, busy, done} !== {k < e.count, k < e.count, k >= e.count}) begin
          errors++;
          $display("FAIL run%0d_ctl k=%0d: en/busy/done got %b%b%b want %b%b%b",
                   r, k, cpu_enable, busy, done,
                   k < e.count, k < e.count, k >= e.count);
        end
        if (k == 0) begin
          vectors++;
          if ({halted, timeout, aborted, ext_conflict} !== 4'b0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL run%0d_clear: flags %b count %0d want 0000 0",
                     r, {halted, timeout, aborted, ext_conflict}, cycle_count);
          end
        end
        start    = (k == cs.p);
        stop     = (k + 1 == cs.s);
        instr_if = (k + 1 == cs.h) ? EBREAK : rand_instr();
        req      = (k == cs.j) ? (one >> jl) : 4'b0000;
        set_host(req);
        #1;
        if (req != 4'b0000) begin
          gexp = (k >= e.count) ? req : 4'b0000;
          vectors++;
          if (gated() !== gexp) begin
            errors++;
            $display("FAIL run%0d_gate k=%0d: got %b want %b", r, k, gated(), gexp);
          end
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      set_host(4'b0000);
      vectors++;
      if ({halted, timeout, aborted} !== {e.halted, e.timeout, e.aborted}) begin
        errors++;
        $display("FAIL run%0d_cause: halt/tmo/abort got %b want %b",
                 r, {halted, timeout, aborted}, {e.halted, e.timeout, e.aborted});
      end
      vectors++;
      if (cycle_count !== CNT_W'(e.count)) begin
        errors++;
        $display("FAIL run%0d_count: got %0d want %0d", r, cycle_count, e.count);
      end
      vectors++;
      if (ext_conflict !== (cs.j >= 0 && cs.j < e.count)) begin
        errors++;
        $display("FAIL run%0d_conflict: got %b want %b",
                 r, ext_conflict, (cs.j >= 0 && cs.j < e.count));
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start      = 1'b1;
    max_cycles = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      instr_if = (k + 1 == 3) ? EBREAK : 32'h00000013;
      @(posedge clk); #1;
    end
    instr_if = 32'h00000013;
    vectors++;
    if ({busy, cpu_enable, halted, done} !== 4'b1110) begin
      errors++;
      $display("FAIL drain_state: busy/en/halt/done got %b want 1110",
               {busy, cpu_enable, halted, done});
    end
    #2;
    arst_n = 1'b0;
    #1;
    vectors++;
    if ({cpu_enable, busy, done, halted, timeout, aborted, ext_conflict} !== 7'b0
        || cycle_count !== '0) begin
      errors++;
      $display("FAIL async_reset: flags %b count %0d want 0000000 0",
               {cpu_enable, busy, done, halted, timeout, aborted, ext_conflict},
               cycle_count);
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef CPU_RUN_STEP_EN
  task automatic test_step();
    start      = 1'b1;
    step_mode  = 1'b1;
    max_cycles = '0;
    @(posedge clk); #1;
    start     = 1'b0;
    step_mode = 1'b0;
    vectors++;
    if ({busy, cpu_enable} !== 2'b10) begin
      errors++;
      $display("FAIL step_idle: busy/en got %b want 10", {busy, cpu_enable});
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      vectors++;
      if (cpu_enable !== 1'b1) begin
        errors++;
        $display("FAIL step%0d_on: got %b want 1", p, cpu_enable);
      end
      @(posedge clk); #1;
      vectors++;
      if (cpu_enable !== 1'b0) begin
        errors++;
        $display("FAIL step%0d_off: got %b want 0", p, cpu_enable);
      end
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    vectors++;
    if ({done, aborted, cpu_enable} !== 3'b110 || cycle_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL step_end: done/abort/en %b count %0d want 110 3",
               {done, aborted, cpu_enable}, cycle_count);
    end
  endtask
`endif

  initial begin
    set_host(4'b0000);
    test_reset();
    test_ext_idle();
    test_runs();
    test_async_reset();
`ifdef CPU_RUN_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the pipelined RISC-V core: drives the core's `enable`, runs a loaded program until ebreak, cycle limit or host abort, then drains the 5-stage pipeline and stops.
- Also arbitrates the external instruction/data memory ports: host access passes only while the core is idle.
- Sits between the testbench/host and `cpu`.

Parameters:
- CNT_W, 32, width of cycle counter and max_cycles
- DRAIN_CYCLES, 4, extra enabled cycles after halt so in-flight instructions reach WB
- HALT_INSTR, 32'h00100073, instruction word (ebreak) that ends a run

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a run
- stop  in  1  pulse; abort run immediately
- max_cycles  in  CNT_W  run limit, sampled on start; 0 = unlimited
- instr_if  in  32  instruction word currently fetched (instruction memory rdata)
- host_wen_ext  in  1  host write request, instruction memory
- host_ren_ext  in  1  host read request, instruction memory
- host_wen_ext_2  in  1  host write request, data memory
- host_ren_ext_2  in  1  host read request, data memory
- cpu_enable  out  1  drives cpu.enable
- wen_ext / ren_ext / wen_ext_2 / ren_ext_2  out  1 each  gated requests to cpu
- busy  out  1  state is RUN or DRAIN
- done  out  1  run finished (level until next start)
- halted  out  1  run ended by HALT_INSTR
- timeout  out  1  run ended by max_cycles
- aborted  out  1  run ended by stop
- ext_conflict  out  1  sticky: host request seen while busy
- cycle_count  out  CNT_W  enabled cycles in current/last run

Behaviour:
- Reset: state IDLE; all outputs 0; cycle_count 0; drain counter 0; latched max 0.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered except the gated ext requests.
- IDLE/DONE, start=1:
  - Next state RUN; latch max_cycles.
  - Clear cycle_count, done, halted, timeout, aborted, ext_conflict.
  - cpu_enable rises the cycle after start (latency 1).
- RUN:
  - cpu_enable=1; cycle_count += 1 per cycle (saturates at all-ones).
  - Exit priority stop > halt > timeout:
    - stop -> DONE, aborted=1, cpu_enable=0 next cycle, no drain.
    - instr_if==HALT_INSTR -> DRAIN, halted=1.
    - latched max!=0 and cycle_count==max-1 -> DRAIN, timeout=1, so exactly max enabled RUN cycles.
- DRAIN:
  - cpu_enable=1; cycle_count keeps counting; drain counter counts DRAIN_CYCLES cycles, then DONE.
  - stop during DRAIN -> DONE immediately, aborted=1, halted/timeout retained.
  - DRAIN_CYCLES=0 goes straight to DONE.
- DONE: cpu_enable=0, done=1.
- start while busy is ignored; start and stop together in IDLE is treated as start only.
- Ext gating (combinational): each gated output = host request & ~busy.
  - Any host request while busy sets ext_conflict.
  - Address/data buses are not routed here; they go directly to cpu.
- The controller does not reset the core; a fresh run from PC 0 requires arst_n. Mid-run arst_n forces IDLE, cpu_enable=0 asynchronously.

Optional Feature:
- Macro: CPU_RUN_STEP_EN.
- Defined:
  - Adds input `step` (1 bit) and input `step_mode` (1 bit, sampled on start).
  - In step mode, RUN asserts cpu_enable for exactly one cycle per step pulse; cycle_count advances only on those cycles.
  - halt/timeout/stop rules unchanged; DRAIN still runs freely.
- Undefined: ports absent; RUN is always free-running.

Decomposition:
- Shared package cpu_ctrl_pkg: state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3) and the HALT_INSTR default constant (EBREAK).
- One natural sub-module: run_cycle_counter (CNT_W saturating counter with clear, enable, terminal-match output), reused for the drain counter.

Test Plan:
- Reset, then start with max_cycles=0, HALT_INSTR presented at enabled cycle 10 -> 4 drain cycles; done=1, halted=1, cycle_count=14, cpu_enable=0.
- max_cycles=20 and no halt -> exactly 20 RUN cycles + 4 DRAIN cycles; timeout=1, cycle_count=24.
- stop pulsed at cycle 5 of RUN -> next cycle cpu_enable=0, done=1, aborted=1, cycle_count=5.
- host_wen_ext=1 during RUN -> wen_ext stays 0 and ext_conflict=1. Same request in IDLE -> wen_ext=1; ext_conflict cleared by the next start.
- Halt and timeout on the same cycle (max_cycles=8, ebreak at cycle 8) -> halted=1, timeout=0. arst_n pulsed mid-DRAIN -> all outputs 0 immediately.
- CPU_RUN_STEP_EN, step_mode=1, three step pulses -> three single-cycle cpu_enable pulses; cycle_count=3.
